// File: rtl/mem_responder_if.sv
// Tagged memory query/answer bus between cache initiators and the memory responder.
// Master drives the query; slave returns the accept tag and the delayed answer.
interface mem_responder_if #(
    parameter int TAG_LEN = 4,
    parameter int IDX_LEN = 29,
    parameter int BLK_LEN = 64
);
    logic [1:0]         qry_cmd;
    logic [IDX_LEN-1:0] qry_idx;
    logic [BLK_LEN-1:0] qry_blk;
    logic [TAG_LEN-1:0] ack;
    logic [TAG_LEN-1:0] ans_tag;
    logic [BLK_LEN-1:0] ans_blk;

    modport master (
        output qry_cmd, qry_idx, qry_blk,
        input  ack, ans_tag, ans_blk
    );

    modport slave (
        input  qry_cmd, qry_idx, qry_blk,
        output ack, ans_tag, ans_blk
    );
endinterface

// File: rtl/mem_responder.sv
// Block RAM responder: tags each accepted load/store and answers it a fixed
// number of cycles later, in order, from an in-order pending FIFO.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int TAG_LEN = 4,
    parameter int IDX_LEN = 29,
    parameter int DEPTH   = 1024,
    parameter int BLK_LEN = 64
) (
    input logic           clock,
    input logic           reset_n,
    mem_responder_if.slave bus
);
    localparam int NSLOT = 2**TAG_LEN - 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int TS_W  = $clog2(LATENCY + 1);

    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef logic [TAG_LEN-1:0] ptr_t;

    logic [BLK_LEN-1:0] mem_q [DEPTH];

    ptr_t               slot_tag_q [2**TAG_LEN];
    logic [AW-1:0]      slot_idx_q [2**TAG_LEN];
    logic [TS_W-1:0]    slot_ts_q  [2**TAG_LEN];

    ptr_t               next_tag_q, next_tag_d;
    ptr_t               cnt_q, cnt_d;
    ptr_t               wr_ptr_q, wr_ptr_d;
    ptr_t               rd_ptr_q, rd_ptr_d;
    logic [TS_W-1:0]    now_q, now_d;
    ptr_t               ans_tag_q, ans_tag_d;
    logic [BLK_LEN-1:0] ans_blk_q, ans_blk_d;

    logic               is_req;
    logic               acc;
    logic               done;
    logic [TS_W-1:0]    head_age;
    logic [AW-1:0]      req_idx;
    logic               unused_idx;

    assign req_idx    = bus.qry_idx[AW-1:0];
    assign unused_idx = ^bus.qry_idx[IDX_LEN-1:AW];

    function automatic ptr_t bump(input ptr_t p);
        return (p == ptr_t'(NSLOT - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        is_req     = (bus.qry_cmd == CMD_LOAD) ||
                     (bus.qry_cmd == CMD_STORE);
        head_age   = now_q - slot_ts_q[rd_ptr_q];
        // Head leaves one edge early so its answer shows in cycle T+LATENCY
        done       = (cnt_q != '0) &&
                     (head_age == TS_W'(LATENCY - 1));
        acc        = reset_n && is_req &&
                     (cnt_q != ptr_t'(NSLOT));

        bus.ack    = acc ? next_tag_q : '0;

        next_tag_d = next_tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        now_d      = now_q + TS_W'(1);
        ans_tag_d  = '0;
        ans_blk_d  = '0;

        if (acc) begin
            next_tag_d = (next_tag_q == ptr_t'(NSLOT)) ?
                         ptr_t'(1) : next_tag_q + ptr_t'(1);
            wr_ptr_d   = bump(wr_ptr_q);
        end

        if (done) begin
            rd_ptr_d  = bump(rd_ptr_q);
            ans_tag_d = slot_tag_q[rd_ptr_q];
            ans_blk_d = mem_q[slot_idx_q[rd_ptr_q]];
        end

        cnt_d = cnt_q + ptr_t'(acc) - ptr_t'(done);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_tag_q <= ptr_t'(1);
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            now_q      <= '0;
            ans_tag_q  <= '0;
            ans_blk_q  <= '0;
        end else begin
            next_tag_q <= next_tag_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            now_q      <= now_d;
            ans_tag_q  <= ans_tag_d;
            ans_blk_q  <= ans_blk_d;
        end
    end

    // Slot payload needs no reset: entries are only read while counted
    always_ff @(posedge clock) begin
        if (acc) begin
            slot_tag_q[wr_ptr_q] <= next_tag_q;
            slot_idx_q[wr_ptr_q] <= req_idx;
            slot_ts_q[wr_ptr_q]  <= now_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (acc && (bus.qry_cmd == CMD_STORE)) begin
            mem_q[req_idx] <= bus.qry_blk;
        end
    end

    assign bus.ans_tag = ans_tag_q;
    assign bus.ans_blk = ans_blk_q;
endmodule
